// File: rtl/round_if.sv
// Control/status bundle between a round controller and its surrounding logic.
// The slave modport is the controller's view; the master modport is the driver's view.
interface round_if #(
  parameter int unsigned LIMIT_W = 5
);
  logic               start;
  logic               pause;
  logic               stop;
  logic [LIMIT_W-1:0] limit;
  logic [LIMIT_W-1:0] tmout;
  logic [1:0]         timer_ctrl;
  logic               running;
  logic               paused;
  logic               expired;
  logic               done;
  logic [LIMIT_W-1:0] remaining;

  modport slave (
    input  start, pause, stop, limit, tmout,
    output timer_ctrl, running, paused, expired, done, remaining
  );

  modport master (
    output start, pause, stop, limit, tmout,
    input  timer_ctrl, running, paused, expired, done, remaining
  );
endinterface

// File: rtl/round_ctrl.sv
// Round controller: sequences an external elapsed-time counter through clear/count/hold
// and reports run, pause, expiry and time remaining.
module round_ctrl #(
  parameter int unsigned LIMIT_W = 5
) (
  input  logic   clk,
  input  logic   rst,
  round_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    EXPIRED = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic               expired_q, expired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          limit_d = bus.limit;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.tmout >= limit_q) begin
          state_d   = EXPIRED;
          expired_d = 1'b1;
        end else if (bus.start) begin
          limit_d = bus.limit;
          state_d = CLEAR;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          limit_d = bus.limit;
          state_d = CLEAR;
        end else if (bus.pause) begin
          state_d = RUN;
        end
      end
      EXPIRED: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          limit_d = bus.limit;
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.timer_ctrl = 2'b00;
    bus.running    = 1'b0;
    bus.paused     = 1'b0;
    bus.done       = 1'b0;
    bus.remaining  = '0;
    bus.expired    = expired_q;
    case (state_q)
      CLEAR: begin
        bus.timer_ctrl = 2'b01;
        bus.remaining  = limit_q;
      end
      RUN: begin
        bus.timer_ctrl = 2'b10;
        bus.running    = 1'b1;
        bus.remaining  = (bus.tmout > limit_q) ? '0 : limit_q - bus.tmout;
      end
      PAUSE: begin
        bus.paused    = 1'b1;
        bus.remaining = (bus.tmout > limit_q) ? '0 : limit_q - bus.tmout;
      end
      EXPIRED: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed scenarios plus randomized traffic checked against
// an event-level model of the round rules and a prescaled timer attached to timer_ctrl.
module tb_round_ctrl;
  localparam int unsigned LW = 5;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_if #(.LIMIT_W(LW)) bus();
  round_ctrl #(.LIMIT_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Timer block: clear on 01, advance tmout once per 12 count cycles on 10.
  logic          use_timer;
  logic [LW-1:0] tstub;
  logic [LW-1:0] tcount;
  logic [3:0]    pre;
  assign bus.tmout = use_timer ? tcount : tstub;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tcount <= '0;
      pre    <= '0;
    end else if (bus.timer_ctrl == 2'b01) begin
      tcount <= '0;
      pre    <= '0;
    end else if (bus.timer_ctrl == 2'b10) begin
      if (pre == 4'd11) begin
        pre    <= '0;
        tcount <= tcount + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  int          m_state;
  int          m_limit;
  logic        m_exp;

  task automatic m_reset();
    m_state = M_IDLE;
    m_limit = 0;
    m_exp   = 1'b0;
  endtask

  function automatic logic [1:0] exp_tc();
    return (m_state == M_CLEAR) ? 2'b01 : (m_state == M_RUN) ? 2'b10 : 2'b00;
  endfunction

  function automatic int exp_rem();
    int t;
    t = int'(bus.tmout);
    if (m_state == M_RUN || m_state == M_PAUSE) return (t > m_limit) ? 0 : m_limit - t;
    if (m_state == M_CLEAR) return m_limit;
    return 0;
  endfunction

  // One clock: sample the inputs the DUT will see, advance the model across the edge.
  task automatic tick();
    logic s_start, s_pause, s_stop;
    int   s_lim, s_tm;
    #1;
    s_start = bus.start; s_pause = bus.pause; s_stop = bus.stop;
    s_lim = int'(bus.limit); s_tm = int'(bus.tmout);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      m_exp = 1'b0;
      if (m_state == M_CLEAR) m_state = M_RUN;
      else if (m_state != M_IDLE && s_stop) m_state = M_IDLE;
      else if (m_state == M_RUN && s_tm >= m_limit) begin
        m_state = M_EXP;
        m_exp   = 1'b1;
      end else if (s_start) begin
        m_state = M_CLEAR;
        m_limit = s_lim;
      end else if (s_pause && m_state == M_RUN) m_state = M_PAUSE;
      else if (s_pause && m_state == M_PAUSE) m_state = M_RUN;
    end
    #1;
  endtask

  task automatic clr_in();
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic go_idle();
    clr_in();
    rst = 1'b1;
    #2;
    m_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic begin_round(input int lim);
    bus.limit = LW'(lim);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr_in();
    use_timer = 1'b0;
    tstub     = 5'd9;
    bus.limit = 5'd7;
    rst = 1'b1;
    #3;
    m_reset();
    total += 6;
    if (bus.timer_ctrl !== 2'b00) begin bad++; $display("FAIL reset_timer_ctrl got=%b exp=00", bus.timer_ctrl); end
    if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    if (bus.paused !== 1'b0) begin bad++; $display("FAIL reset_paused got=%b exp=0", bus.paused); end
    if (bus.expired !== 1'b0) begin bad++; $display("FAIL reset_expired got=%b exp=0", bus.expired); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.remaining !== 5'd0) begin bad++; $display("FAIL reset_remaining got=%0d exp=0", bus.remaining); end
    tick();
    rst = 1'b0;
    bus.pause = 1'b1;
    bus.stop  = 1'b1;
    tick();
    clr_in();
    total++;
    if (bus.timer_ctrl !== 2'b00 || bus.running !== 1'b0) begin
      bad++; $display("FAIL idle_ignores_pause_stop got tc=%b run=%b exp tc=00 run=0", bus.timer_ctrl, bus.running);
    end
  endtask

  task automatic test_nominal();
    int first_exp, pulses;
    go_idle();
    use_timer = 1'b1;
    bus.limit = 5'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total += 2;
    if (bus.timer_ctrl !== 2'b01) begin bad++; $display("FAIL nom_clear_tc got=%b exp=01", bus.timer_ctrl); end
    if (bus.remaining !== 5'd2) begin bad++; $display("FAIL nom_clear_rem got=%0d exp=2", bus.remaining); end
    tick();
    total++;
    if (bus.timer_ctrl !== 2'b10 || bus.running !== 1'b1) begin
      bad++; $display("FAIL nom_run got tc=%b run=%b exp tc=10 run=1", bus.timer_ctrl, bus.running);
    end
    first_exp = -1;
    pulses    = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.expired === 1'b1) begin
        pulses++;
        if (first_exp < 0) first_exp = i;
      end
    end
    total += 5;
    if (first_exp != 25) begin bad++; $display("FAIL nom_expiry_time got=%0d exp=25", first_exp); end
    if (pulses != 1) begin bad++; $display("FAIL nom_expired_pulses got=%0d exp=1", pulses); end
    if (bus.done !== 1'b1) begin bad++; $display("FAIL nom_done got=%b exp=1", bus.done); end
    if (bus.timer_ctrl !== 2'b00) begin bad++; $display("FAIL nom_done_tc got=%b exp=00", bus.timer_ctrl); end
    if (bus.remaining !== 5'd0) begin bad++; $display("FAIL nom_done_rem got=%0d exp=0", bus.remaining); end
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    total++;
    if (bus.done !== 1'b1 || bus.paused !== 1'b0) begin
      bad++; $display("FAIL nom_exp_ignores_pause got done=%b paused=%b exp done=1 paused=0", bus.done, bus.paused);
    end
  endtask

  task automatic test_pause();
    go_idle();
    use_timer = 1'b0;
    tstub = 5'd0;
    begin_round(5);
    tstub = 5'd3;
    tick();
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    total += 3;
    if (bus.paused !== 1'b1) begin bad++; $display("FAIL pause_paused got=%b exp=1", bus.paused); end
    if (bus.timer_ctrl !== 2'b00) begin bad++; $display("FAIL pause_tc got=%b exp=00", bus.timer_ctrl); end
    if (bus.remaining !== 5'd2) begin bad++; $display("FAIL pause_rem got=%0d exp=2", bus.remaining); end
    tstub = 5'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.expired !== 1'b0 || bus.paused !== 1'b1) begin
        bad++; $display("FAIL pause_no_expiry cyc=%0d got exp=%b paused=%b exp exp=0 paused=1", i, bus.expired, bus.paused);
      end
    end
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    total++;
    if (bus.running !== 1'b1 || bus.expired !== 1'b0) begin
      bad++; $display("FAIL pause_resume got run=%b exp=%b exp run=1 exp=0", bus.running, bus.expired);
    end
    tick();
    total++;
    if (bus.expired !== 1'b1 || bus.done !== 1'b1) begin
      bad++; $display("FAIL pause_then_expire got exp=%b done=%b exp 1 1", bus.expired, bus.done);
    end
  endtask

  task automatic test_same_cycle();
    go_idle();
    use_timer = 1'b0;
    tstub = 5'd0;
    begin_round(4);
    tstub = 5'd4;
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    tick();
    clr_in();
    total++;
    if (bus.expired !== 1'b0 || bus.running !== 1'b0 || bus.paused !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL same_stop_wins got exp=%b run=%b paused=%b done=%b exp all 0",
                      bus.expired, bus.running, bus.paused, bus.done);
    end
    tstub = 5'd0;
    begin_round(4);
    tstub = 5'd4;
    bus.limit = 5'd9;
    bus.start = 1'b1;
    bus.pause = 1'b1;
    tick();
    clr_in();
    total++;
    if (bus.expired !== 1'b1 || bus.done !== 1'b1 || bus.timer_ctrl !== 2'b00) begin
      bad++; $display("FAIL same_expiry_wins got exp=%b done=%b tc=%b exp 1 1 00", bus.expired, bus.done, bus.timer_ctrl);
    end
  endtask

  task automatic test_restart();
    go_idle();
    use_timer = 1'b0;
    tstub = 5'd0;
    begin_round(6);
    tstub = 5'd1;
    tick();
    bus.limit = 5'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total += 2;
    if (bus.timer_ctrl !== 2'b01) begin bad++; $display("FAIL restart_clear_tc got=%b exp=01", bus.timer_ctrl); end
    if (bus.remaining !== 5'd3) begin bad++; $display("FAIL restart_clear_rem got=%0d exp=3", bus.remaining); end
    tstub = 5'd0;
    tick();
    total++;
    if (bus.running !== 1'b1 || bus.remaining !== 5'd3) begin
      bad++; $display("FAIL restart_run got run=%b rem=%0d exp run=1 rem=3", bus.running, bus.remaining);
    end
    tstub = 5'd2;
    #1;
    total++;
    if (bus.remaining !== 5'd1) begin bad++; $display("FAIL restart_new_limit_rem got=%0d exp=1", bus.remaining); end
    tstub = 5'd3;
    tick();
    total++;
    if (bus.expired !== 1'b1) begin bad++; $display("FAIL restart_new_limit_expiry got=%b exp=1", bus.expired); end
  endtask

  task automatic test_reset_zero();
    go_idle();
    use_timer = 1'b1;
    begin_round(5);
    tick();
    rst = 1'b1;
    #2;
    total++;
    if (bus.timer_ctrl !== 2'b00 || bus.running !== 1'b0 || bus.paused !== 1'b0 ||
        bus.expired !== 1'b0 || bus.done !== 1'b0 || bus.remaining !== 5'd0) begin
      bad++; $display("FAIL midrun_reset got tc=%b run=%b p=%b e=%b d=%b rem=%0d exp all 0",
                      bus.timer_ctrl, bus.running, bus.paused, bus.expired, bus.done, bus.remaining);
    end
    tick();
    total++;
    if (bus.expired !== 1'b0 || bus.running !== 1'b0) begin
      bad++; $display("FAIL reset_held got exp=%b run=%b exp 0 0", bus.expired, bus.running);
    end
    rst = 1'b0;
    m_reset();
    bus.limit = 5'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.timer_ctrl !== 2'b01) begin bad++; $display("FAIL zero_clear got=%b exp=01", bus.timer_ctrl); end
    tick();
    total++;
    if (bus.running !== 1'b1 || bus.expired !== 1'b0) begin
      bad++; $display("FAIL zero_run got run=%b exp=%b exp 1 0", bus.running, bus.expired);
    end
    tick();
    total++;
    if (bus.expired !== 1'b1 || bus.done !== 1'b1) begin
      bad++; $display("FAIL zero_expire got exp=%b done=%b exp 1 1", bus.expired, bus.done);
    end
  endtask

  task automatic test_saturation();
    go_idle();
    use_timer = 1'b0;
    tstub = 5'd0;
    begin_round(2);
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    tstub = 5'd7;
    #1;
    total++;
    if (bus.remaining !== 5'd0 || bus.paused !== 1'b1) begin
      bad++; $display("FAIL saturate_rem got rem=%0d paused=%b exp rem=0 paused=1", bus.remaining, bus.paused);
    end
    tick();
    total++;
    if (bus.expired !== 1'b0 || bus.remaining !== 5'd0) begin
      bad++; $display("FAIL saturate_hold got exp=%b rem=%0d exp 0 0", bus.expired, bus.remaining);
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int c = 0; c < 1200; c++) begin
      use_timer = (c >= 600);
      tstub     = LW'($urandom_range(0, 12));
      bus.limit = use_timer ? LW'($urandom_range(0, 3)) : LW'($urandom_range(0, 12));
      bus.start = ($urandom_range(0, 9) == 0);
      bus.pause = ($urandom_range(0, 7) == 0);
      bus.stop  = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      tick();
      rst = 1'b0;
      total += 7;
      if (bus.timer_ctrl !== exp_tc()) begin bad++; $display("FAIL rnd_tc cyc=%0d got=%b exp=%b", c, bus.timer_ctrl, exp_tc()); end
      if (bus.running !== (m_state == M_RUN)) begin bad++; $display("FAIL rnd_running cyc=%0d got=%b exp=%b", c, bus.running, m_state == M_RUN); end
      if (bus.paused !== (m_state == M_PAUSE)) begin bad++; $display("FAIL rnd_paused cyc=%0d got=%b exp=%b", c, bus.paused, m_state == M_PAUSE); end
      if (bus.done !== (m_state == M_EXP)) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, bus.done, m_state == M_EXP); end
      if (bus.expired !== m_exp) begin bad++; $display("FAIL rnd_expired cyc=%0d got=%b exp=%b", c, bus.expired, m_exp); end
      if (int'(bus.remaining) != exp_rem() || $isunknown(bus.remaining)) begin
        bad++; $display("FAIL rnd_remaining cyc=%0d got=%0d exp=%0d", c, bus.remaining, exp_rem());
      end
      if (int'(bus.tmout) >= 0 && m_state == M_RUN && bus.timer_ctrl !== 2'b10) begin
        bad++; $display("FAIL rnd_run_counts cyc=%0d got=%b exp=10", c, bus.timer_ctrl);
      end
    end
    clr_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    use_timer = 1'b0;
    tstub = '0;
    bus.limit = '0;
    clr_in();
    m_reset();
    test_reset();
    test_nominal();
    test_pause();
    test_same_cycle();
    test_restart();
    test_reset_zero();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
